// File: rtl/pcie_vc_switch.sv
// pcie_vc_switch: NUM_CH class-queued VC FIFOs feeding NUM_CH destination
// FIFOs via one round-robin arbiter, with watermarks, config FSM, counters.
module pcie_vc_switch #(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 5,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int TH_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [TH_W-1:0]          umbral_L,
  input  logic [TH_W-1:0]          umbral_H,
  input  logic                     push,
  input  logic [DATA_W-1:0]        data_in,
  output logic [NUM_CH-1:0]        in_full,
  input  logic [NUM_CH-1:0]        pop,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        out_empty,
  output logic [NUM_CH-1:0]        out_almost_empty,
  input  logic                     req,
  input  logic [CH_W:0]            idx,
  output logic [CNT_W-1:0]         cnt_data,
  output logic                     cnt_valid,
  output logic                     idle,
  output logic                     error
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [TH_W-1:0] FULL = TH_W'(DEPTH);
  localparam logic [CH_W:0] ING_IDX = (CH_W+1)'(NUM_CH);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE} state_t;
  state_t state;

  logic [DATA_W-1:0] vc_mem [NUM_CH][DEPTH];
  logic [DATA_W-1:0] dq_mem [NUM_CH][DEPTH];
  logic [PW-1:0]     vc_rd  [NUM_CH];
  logic [PW-1:0]     vc_wr  [NUM_CH];
  logic [PW-1:0]     dq_rd  [NUM_CH];
  logic [PW-1:0]     dq_wr  [NUM_CH];
  logic [TH_W-1:0]   vc_occ [NUM_CH];
  logic [TH_W-1:0]   dq_occ [NUM_CH];
  logic [CNT_W-1:0]  pop_cnt [NUM_CH];
  logic [CNT_W-1:0]  ing_cnt;
  logic [TH_W-1:0]   th_l;
  logic [TH_W-1:0]   th_h;
  logic [CH_W-1:0]   rr_ptr;

  logic [DATA_W-1:0] vc_head  [NUM_CH];
  logic [CH_W-1:0]   head_dst [NUM_CH];
  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] wr_dq;
  logic [NUM_CH-1:0] pop_ok;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   sel;
  logic              gnt_vld;
  logic [CH_W-1:0]   in_cls;
  logic              push_en;
  logic              push_ok;
  logic              push_drop;
  logic              pop_bad;
  logic              all_empty;

  always_comb begin
    gnt_vld   = 1'b0;
    gnt       = '0;
    sel       = '0;
    cand      = '0;
    wr_dq     = '0;
    pop_ok    = '0;
    all_empty = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      vc_head[i]  = vc_mem[i][vc_rd[i]];
      head_dst[i] = vc_head[i][DATA_W-CH_W-1 -: CH_W];
      // a head may move only if its destination has headroom
      cand[i] = (vc_occ[i] != '0) &&
                (dq_occ[head_dst[i]] < th_h) &&
                (dq_occ[head_dst[i]] != FULL);
      pop_ok[i] = pop[i] && (dq_occ[i] != '0);
      if (vc_occ[i] != '0 || dq_occ[i] != '0)
        all_empty = 1'b0;
    end
    for (int off = 0; off < NUM_CH; off++) begin
      sel = rr_ptr + CH_W'(off);
      if (!gnt_vld && cand[sel] && state != S_INIT) begin
        gnt_vld = 1'b1;
        gnt     = sel;
      end
    end
    if (gnt_vld)
      wr_dq[head_dst[gnt]] = 1'b1;
    in_cls    = data_in[DATA_W-1 -: CH_W];
    push_en   = push && (state != S_INIT);
    push_ok   = push_en && ((vc_occ[in_cls] != FULL) ||
                            (gnt_vld && gnt == in_cls));
    push_drop = push_en && !push_ok;
    pop_bad   = |(pop & ~pop_ok);
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_full[i]          = vc_occ[i] >= th_h;
      out_empty[i]        = dq_occ[i] == '0;
      out_almost_empty[i] = dq_occ[i] <= th_l;
      data_out[i*DATA_W +: DATA_W] = dq_mem[i][dq_rd[i]];
    end
  end

  assign idle = (state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          vc_mem[i][j] <= '0;
          dq_mem[i][j] <= '0;
        end
        vc_rd[i]  <= '0;
        vc_wr[i]  <= '0;
        dq_rd[i]  <= '0;
        dq_wr[i]  <= '0;
        vc_occ[i] <= '0;
        dq_occ[i] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_ok && in_cls == CH_W'(i)) begin
          vc_mem[i][vc_wr[i]] <= data_in;
          vc_wr[i] <= vc_wr[i] + PW'(1);
        end
        if (gnt_vld && gnt == CH_W'(i))
          vc_rd[i] <= vc_rd[i] + PW'(1);
        vc_occ[i] <= vc_occ[i]
                   + TH_W'(push_ok && in_cls == CH_W'(i))
                   - TH_W'(gnt_vld && gnt == CH_W'(i));
        if (wr_dq[i]) begin
          dq_mem[i][dq_wr[i]] <= vc_head[gnt];
          dq_wr[i] <= dq_wr[i] + PW'(1);
        end
        if (pop_ok[i])
          dq_rd[i] <= dq_rd[i] + PW'(1);
        dq_occ[i] <= dq_occ[i] + TH_W'(wr_dq[i]) - TH_W'(pop_ok[i]);
      end
      if (gnt_vld)
        rr_ptr <= gnt + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_INIT;
      th_h  <= TH_W'(DEPTH - 1);
      th_l  <= TH_W'(1);
    end else if (init) begin
      state <= S_INIT;
      th_h  <= umbral_H;
      th_l  <= umbral_L;
    end else begin
      unique case (state)
        S_INIT:   state <= S_IDLE;
        S_IDLE:   if (!all_empty) state <= S_ACTIVE;
        S_ACTIVE: if (all_empty) state <= S_IDLE;
        default:  state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++)
        pop_cnt[i] <= '0;
      ing_cnt   <= '0;
      cnt_data  <= '0;
      cnt_valid <= 1'b0;
      error     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (pop_ok[i])
          pop_cnt[i] <= pop_cnt[i] + CNT_W'(1);
      if (push_ok)
        ing_cnt <= ing_cnt + CNT_W'(1);
      if (push_drop || pop_bad)
        error <= 1'b1;
      if (state == S_IDLE && req) begin
        cnt_valid <= 1'b1;
        if (idx < ING_IDX)
          cnt_data <= pop_cnt[idx[CH_W-1:0]];
        else if (idx == ING_IDX)
          cnt_data <= ing_cnt;
        else
          cnt_data <= '0;
      end else begin
        cnt_valid <= 1'b0;
        cnt_data  <= '0;
      end
    end
  end

endmodule
